// File: rtl/stream_mux_rr.sv
// stream_mux_rr: round-robin N-to-1 packet stream mux with a one-entry registered output stage
module stream_mux_rr #(
  parameter int N_CH = 2,
  parameter int DW   = 8,
  parameter int SW   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic [N_CH*DW-1:0] in_data,
  input  logic [N_CH-1:0]   in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_last,
  output logic [SW-1:0]     out_sel
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [SW-1:0] grant, ptr, pick;
  logic [DW-1:0] sel_data;
  logic sel_last, xfer;
  int best;
  // round-robin pick: requester with the smallest distance past ptr wins
  always_comb begin
    pick = '0;
    best = N_CH;
    for (int i = 0; i < N_CH; i++)
      if (in_valid[i] && (i + N_CH - 1 - int'(ptr)) % N_CH < best) begin
        best = (i + N_CH - 1 - int'(ptr)) % N_CH;
        pick = SW'(i);
      end
  end
  // beat and end-of-packet flag of the granted channel
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (grant == SW'(i)) begin
        sel_data = in_data[i*DW +: DW];
        sel_last = in_last[i];
      end
  end
  assign in_ready = (state == BUSY && (!out_valid || out_ready)) ? N_CH'(1) << grant : '0;
  assign xfer = |(in_valid & in_ready);
  // arbitration FSM, pointer update on last beat, and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= SW'(N_CH - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else begin
      if (state == IDLE && |in_valid) begin
        grant <= pick;
        state <= BUSY;
      end
      if (xfer && sel_last) begin
        ptr   <= grant;
        state <= IDLE;
      end
      out_valid <= xfer || (out_valid && !out_ready);
      if (xfer) begin
        out_data <= sel_data;
        out_last <= sel_last;
        out_sel  <= grant;
      end
    end
  end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed and randomized checks of the round-robin packet mux
module tb_stream_mux_rr;
  localparam int N = 2, DW = 8, SW = 1;
  typedef logic [DW:0] beat_t;
  typedef logic [SW+DW:0] obeat_t;
  logic clk = 1'b0, rst = 1'b1, out_ready = 1'b0;
  logic [N-1:0] in_valid, in_ready, in_last, src_en = '1, rdy_s;
  logic [N*DW-1:0] in_data;
  logic out_valid, out_last;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_sel;
  beat_t src_q[N][$];
  beat_t mq[N][$];
  obeat_t out_log[$];
  obeat_t exp_q[$];
  int n_cmp = 0, n_err = 0, last_ch = 0;

  stream_mux_rr #(.N_CH(N), .DW(DW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid[i] = src_en[i] && src_q[i].size() > 0;
      {in_last[i], in_data[i*DW +: DW]} = in_valid[i] ? src_q[i][0] : '0;
    end
  endtask

  task automatic cyc();
    logic [N-1:0] hs;
    drive();
    #1;
    rdy_s = in_ready;
    hs = in_valid & in_ready;
    if (out_valid && out_ready && !rst) out_log.push_back({out_sel, out_last, out_data});
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i] && !rst) void'(src_q[i].pop_front());
  endtask

  task automatic push(int ch, logic l, logic [DW-1:0] d);
    src_q[ch].push_back({l, d});
  endtask

  task automatic ex(logic s, logic l, logic [DW-1:0] d);
    exp_q.push_back({s, l, d});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    cyc();
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_cmp++; if ({out_last, out_sel} !== '0) begin n_err++; $display("FAIL reset_last_sel: got %b want 00", {out_last, out_sel}); end
    n_cmp++; if (in_ready !== '0) begin n_err++; $display("FAIL reset_in_ready: got %b want 00", in_ready); end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_out_valid%0d: got %b want 0", k, out_valid); end
      n_cmp++; if (rdy_s !== '0) begin n_err++; $display("FAIL idle_in_ready%0d: got %b want 00", k, rdy_s); end
    end
  endtask

  task automatic test_single();
    logic ev;
    out_ready = 1'b1;
    push(1, 1'b0, 8'hA1);
    push(1, 1'b0, 8'hA2);
    push(1, 1'b1, 8'hA3);
    for (int k = 0; k < 5; k++) begin
      cyc();
      ev = k >= 1 && k <= 3;
      n_cmp++; if (rdy_s !== (ev ? 2'b10 : 2'b00)) begin n_err++; $display("FAIL single_in_ready%0d: got %b want %b", k, rdy_s, ev ? 2'b10 : 2'b00); end
      n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL single_out_valid%0d: got %b want %b", k, out_valid, ev); end
      if (ev) begin
        n_cmp++;
        if ({out_sel, out_last, out_data} !== {1'b1, k == 3, 8'hA0 + 8'(k)}) begin
          n_err++; $display("FAIL single_beat%0d: got %h want %h", k, {out_sel, out_last, out_data}, {1'b1, k == 3, 8'hA0 + 8'(k)});
        end
      end
    end
    last_ch = 1;
  endtask

  task automatic test_contention();
    out_ready = 1'b1;
    out_log.delete();
    exp_q.delete();
    push(0, 1'b0, 8'h10); push(0, 1'b1, 8'h11);
    push(1, 1'b0, 8'h20); push(1, 1'b1, 8'h21);
    ex(0, 0, 8'h10); ex(0, 1, 8'h11); ex(1, 0, 8'h20); ex(1, 1, 8'h21);
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k == 1 || k == 2) begin
        n_cmp++; if (rdy_s !== 2'b01) begin n_err++; $display("FAIL contention_in_ready%0d: got %b want 01", k, rdy_s); end
      end
    end
    n_cmp++;
    if (out_log.size() != exp_q.size()) begin n_err++; $display("FAIL contention_count: got %0d want %0d", out_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) begin
      n_cmp++;
      if (out_log[i] !== exp_q[i]) begin n_err++; $display("FAIL contention_beat%0d: got %h want %h", i, out_log[i], exp_q[i]); end
    end
    last_ch = 1;
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b1;
    out_log.delete();
    exp_q.delete();
    push(0, 1'b0, 8'h5A); push(0, 1'b0, 8'h5B); push(0, 1'b1, 8'h5C);
    ex(0, 0, 8'h5A); ex(0, 0, 8'h5B); ex(0, 1, 8'h5C);
    cyc();
    cyc();
    n_cmp++; if ({out_valid, out_data} !== {1'b1, 8'h5A}) begin n_err++; $display("FAIL bp_first: got %h want 15a", {out_valid, out_data}); end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_cmp++; if ({out_valid, out_data} !== {1'b1, 8'h5A}) begin n_err++; $display("FAIL bp_hold%0d: got %h want 15a", k, {out_valid, out_data}); end
      n_cmp++; if (rdy_s !== 2'b00) begin n_err++; $display("FAIL bp_in_ready%0d: got %b want 00", k, rdy_s); end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) cyc();
    n_cmp++;
    if (out_log.size() != exp_q.size()) begin n_err++; $display("FAIL bp_count: got %0d want %0d", out_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) begin
      n_cmp++;
      if (out_log[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_beat%0d: got %h want %h", i, out_log[i], exp_q[i]); end
    end
    last_ch = 0;
  endtask

  task automatic test_gap();
    out_ready = 1'b1;
    out_log.delete();
    exp_q.delete();
    push(0, 1'b0, 8'h30); push(0, 1'b0, 8'h31); push(0, 1'b1, 8'h32);
    ex(0, 0, 8'h30); ex(0, 0, 8'h31); ex(0, 1, 8'h32); ex(1, 0, 8'h40); ex(1, 1, 8'h41);
    src_en = 2'b01;
    cyc();
    cyc();
    push(1, 1'b0, 8'h40); push(1, 1'b1, 8'h41);
    src_en = 2'b10;
    for (int k = 0; k < 2; k++) begin
      cyc();
      n_cmp++; if (rdy_s !== 2'b01) begin n_err++; $display("FAIL gap_in_ready%0d: got %b want 01", k, rdy_s); end
    end
    src_en = 2'b11;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k < 2) begin
        n_cmp++; if (rdy_s !== 2'b01) begin n_err++; $display("FAIL gap_resume_in_ready%0d: got %b want 01", k, rdy_s); end
      end
    end
    n_cmp++;
    if (out_log.size() != exp_q.size()) begin n_err++; $display("FAIL gap_count: got %0d want %0d", out_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) begin
      n_cmp++;
      if (out_log[i] !== exp_q[i]) begin n_err++; $display("FAIL gap_beat%0d: got %h want %h", i, out_log[i], exp_q[i]); end
    end
    last_ch = 1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    push(0, 1'b1, 8'h5F);
    for (int k = 0; k < 4; k++) cyc();
    out_ready = 1'b0;
    push(1, 1'b0, 8'h60); push(1, 1'b1, 8'h61);
    cyc();
    cyc();
    n_cmp++; if ({out_valid, out_sel, out_data} !== {1'b1, 1'b1, 8'h60}) begin n_err++; $display("FAIL rstmid_pre: got %h want 360", {out_valid, out_sel, out_data}); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL rstmid_out_data: got %h want 00", out_data); end
    src_q[0].delete();
    src_q[1].delete();
    out_ready = 1'b1;
    out_log.delete();
    exp_q.delete();
    push(0, 1'b1, 8'h70); push(1, 1'b1, 8'h80);
    ex(0, 1, 8'h70); ex(1, 1, 8'h80);
    cyc();
    n_cmp++; if (rdy_s !== 2'b00) begin n_err++; $display("FAIL rstmid_idle_in_ready: got %b want 00", rdy_s); end
    for (int k = 0; k < 5; k++) cyc();
    n_cmp++;
    if (out_log.size() != exp_q.size()) begin n_err++; $display("FAIL rstmid_count: got %0d want %0d", out_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) begin
      n_cmp++;
      if (out_log[i] !== exp_q[i]) begin n_err++; $display("FAIL rstmid_beat%0d: got %h want %h", i, out_log[i], exp_q[i]); end
    end
    last_ch = 1;
  endtask

  task automatic test_random_fair();
    int ch, c, cycles, len;
    beat_t b;
    out_log.delete();
    exp_q.delete();
    src_en = '1;
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 5; p++) begin
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) push(i, j == len - 1, DW'($urandom));
      end
    for (int i = 0; i < N; i++) mq[i] = src_q[i];
    ch = last_ch;
    while (mq[0].size() + mq[1].size() > 0) begin
      c = ch;
      for (int k = N; k >= 1; k--) if (mq[(ch + k) % N].size() > 0) c = (ch + k) % N;
      do begin
        b = mq[c].pop_front();
        exp_q.push_back({SW'(c), b});
      end while (!b[DW]);
      ch = c;
    end
    cycles = 0;
    while (out_log.size() < exp_q.size() && cycles < 2000) begin
      out_ready = $urandom_range(0, 3) != 0;
      cyc();
      cycles++;
    end
    n_cmp++;
    if (out_log.size() != exp_q.size()) begin n_err++; $display("FAIL fair_count: got %0d want %0d", out_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) begin
      n_cmp++;
      if (out_log[i] !== exp_q[i]) begin n_err++; $display("FAIL fair_beat%0d: got %h want %h", i, out_log[i], exp_q[i]); end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
  endtask

  task automatic test_random_gaps();
    int cycles, len, total;
    beat_t want;
    obeat_t prev;
    out_log.delete();
    total = 0;
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 6; p++) begin
        len = $urandom_range(1, 4);
        total += len;
        for (int j = 0; j < len; j++) push(i, j == len - 1, DW'($urandom));
      end
    for (int i = 0; i < N; i++) mq[i] = src_q[i];
    cycles = 0;
    while (out_log.size() < total && cycles < 3000) begin
      src_en = N'($urandom);
      out_ready = $urandom_range(0, 2) != 0;
      cyc();
      cycles++;
    end
    n_cmp++;
    if (out_log.size() != total) begin n_err++; $display("FAIL gaps_count: got %0d want %0d", out_log.size(), total); end
    prev = '0;
    prev[DW] = 1'b1;
    foreach (out_log[i]) begin
      if (!prev[DW]) begin
        n_cmp++;
        if (out_log[i][SW+DW] !== prev[SW+DW]) begin n_err++; $display("FAIL gaps_interleave%0d: got sel %b want %b", i, out_log[i][SW+DW], prev[SW+DW]); end
      end
      want = mq[out_log[i][SW+DW]].size() > 0 ? mq[out_log[i][SW+DW]].pop_front() : 'x;
      n_cmp++;
      if (out_log[i][DW:0] !== want) begin n_err++; $display("FAIL gaps_beat%0d: got %h want %h", i, out_log[i][DW:0], want); end
      prev = out_log[i];
    end
  endtask

  initial begin
    drive();
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_gap();
    test_reset_mid();
    test_random_fair();
    test_random_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
